imem_loader: RTL and testbench

- Write-side counterpart to the core's instruction memory.
- Accepts a byte stream with a valid/ready handshake and clears the whole instruction store to NOP.
- Packs incoming bytes little-endian into 32-bit words and writes them sequentially from address 0.
- Holds the core in reset for the whole load, then pulses done.
- Sits between the board-level serial/host byte source and the write port of a writable instruction memory.

---
 rtl/imem_loader_pkg.sv | 19 +
 rtl/imem_loader_if.sv | 30 +++
 rtl/imem_loader_byte_packer.sv | 41 ++++
 rtl/imem_loader.sv | 120 ++++++++++++
 tb/tb_imem_loader.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader shared types and constants.
// Word geometry and fill value for the writable instruction store.
package imem_loader_pkg;

  localparam int ADDR_W = 6;
  localparam int DEPTH  = 1 << ADDR_W;

  // ADDI x0,x0,0
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_WRITE,
    S_DONE
  } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bundle for imem_loader.
// master drives the byte source side, slave is the loader.
interface imem_loader_if;
  import imem_loader_pkg::*;

  logic              start;
  logic [ADDR_W:0]   len;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;
  logic              core_hold;
  logic              busy;
  logic              done;

  modport master (
    output start, len, byte_in, byte_valid,
    input  byte_ready, mem_we, mem_waddr,
    input  mem_wdata, core_hold, busy, done
  );

  modport slave (
    input  start, len, byte_in, byte_valid,
    output byte_ready, mem_we, mem_waddr,
    output mem_wdata, core_hold, busy, done
  );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word assembler.
// word_full flags the cycle the 4th byte of a word is taken.
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic [31:0] word,
  output logic        word_full
);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] word_q, word_d;

  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    if (clr) begin
      cnt_d  = '0;
      word_d = '0;
    end else if (in_valid) begin
      word_d[8*cnt_q +: 8] = in_byte;
      cnt_d = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

  assign word      = word_q;
  assign word_full = in_valid && !clr && (cnt_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: NOP-clears the store, then writes
// a packed byte stream from address 0 while holding the core.
module imem_loader (
  input  logic          clk,
  input  logic          rst,
  imem_loader_if.slave  bus
);
  import imem_loader_pkg::*;

  localparam logic [ADDR_W:0] DEPTH_L =
    (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] IDX_ONE =
    ADDR_W'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W:0]   idx_nxt;

  logic        accept;
  logic        pk_clr;
  logic        pk_full;
  logic [31:0] pk_word;

  assign accept  = (state_q == S_LOAD) && bus.byte_valid;
  assign pk_clr  = (state_q == S_IDLE);
  assign idx_nxt = {1'b0, idx_q} + {1'b0, IDX_ONE};

  byte_packer u_pack (
    .clk       (clk),
    .rst       (rst),
    .clr       (pk_clr),
    .in_valid  (accept),
    .in_byte   (bus.byte_in),
    .word      (pk_word),
    .word_full (pk_full)
  );

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    len_d          = len_q;
    waddr_d        = waddr_q;
    wdata_d        = wdata_q;
    bus.mem_we     = 1'b0;
    bus.byte_ready = 1'b0;
    bus.done       = 1'b0;
    bus.mem_waddr  = waddr_q;
    bus.mem_wdata  = wdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_CLEAR;
          idx_d   = '0;
          len_d   = (bus.len > DEPTH_L) ? DEPTH_L : bus.len;
        end
      end
      S_CLEAR: begin
        bus.mem_we    = 1'b1;
        bus.mem_waddr = idx_q;
        bus.mem_wdata = NOP_WORD;
        if (idx_q == LAST) begin
          idx_d   = '0;
          state_d = (len_q == '0) ? S_DONE : S_LOAD;
        end else begin
          idx_d = idx_nxt[ADDR_W-1:0];
        end
      end
      S_LOAD: begin
        bus.byte_ready = 1'b1;
        if (pk_full) state_d = S_WRITE;
      end
      S_WRITE: begin
        bus.mem_we    = 1'b1;
        bus.mem_waddr = idx_q;
        bus.mem_wdata = pk_word;
        // Index stays on the last word so it never leaves the store
        if (idx_nxt == len_q) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_nxt[ADDR_W-1:0];
          state_d = S_LOAD;
        end
      end
      S_DONE: begin
        bus.done = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (bus.mem_we) begin
      waddr_d = bus.mem_waddr;
      wdata_d = bus.mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.core_hold = (state_q != S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_imem_loader.sv
// Random/directed bench for imem_loader against a
// write-list and memory-image reference model.
module tb_imem_loader;
  import imem_loader_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_loader_if bus ();

  imem_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [37:0] exp_q [$];
  logic [31:0] shadow [DEPTH];
  logic [31:0] model [DEPTH];
  logic [7:0]  stim [$];
  int cyc = 0;
  int start_cyc = 0;
  int lat = 0;
  int ready_cnt = 0;

  function automatic logic [42:0] outs();
    return {bus.mem_we, bus.mem_waddr, bus.mem_wdata,
            bus.byte_ready, bus.core_hold, bus.busy, bus.done};
  endfunction

  // Observes every write and checks it against the expected list
  always @(negedge clk) begin
    logic [37:0] e;
    cyc++;
    if (!rst) begin
      if (bus.start && !bus.busy) start_cyc = cyc;
      if (bus.byte_ready) ready_cnt++;
      if (bus.done) begin
        lat = cyc - start_cyc;
        chk("done_hold", 64'(bus.core_hold), 64'd1);
      end
      if (bus.mem_we) begin
        if (exp_q.size() == 0) begin
          chk("we_unexpected", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("mem_write",
              64'({bus.byte_ready, bus.mem_waddr, bus.mem_wdata}),
              64'({1'b0, e}));
        end
        shadow[bus.mem_waddr] = bus.mem_wdata;
      end
    end
  end

  task automatic cmp_mem();
    for (int i = 0; i < DEPTH; i++)
      chk($sformatf("mem[%0d]", i), 64'(shadow[i]), 64'(model[i]));
  endtask

  task automatic run_load(input int len, input int gap,
                          input bit mid, input int abort_at);
    int neff;
    int nb;
    int rc0;
    int wd;
    bit to;
    logic [7:0] b [$];
    logic [31:0] w;
    neff = (len > DEPTH) ? DEPTH : len;
    nb   = neff * 4;
    for (int k = 0; k < nb; k++)
      b.push_back((stim.size() >= nb) ? stim[k] : 8'($urandom));
    for (int i = 0; i < DEPTH; i++) begin
      model[i] = NOP_WORD;
      exp_q.push_back({6'(i), NOP_WORD});
    end
    for (int i = 0; i < neff; i++) begin
      w = 32'(b[4*i]) + (32'(b[4*i+1]) << 8) +
          (32'(b[4*i+2]) << 16) + (32'(b[4*i+3]) << 24);
      model[i] = w;
      exp_q.push_back({6'(i), w});
    end
    rc0 = ready_cnt;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.len   = 7'(len);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.len   = 7'($urandom);
    for (int k = 0; k < nb; k++) begin
      if (k == abort_at) begin
        wd = k / 4;
        bus.byte_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_outs", 64'(outs()), 64'd0);
        chk("abort_pending", 64'(exp_q.size()), 64'(neff - wd));
        exp_q.delete();
        for (int i = wd; i < DEPTH; i++) model[i] = NOP_WORD;
        cmp_mem();
        return;
      end
      if (gap > 0 && k > 0) begin
        bus.byte_valid = 1'b0;
        bus.byte_in = 8'($urandom);
        repeat (gap) @(posedge clk);
        #1;
      end
      bus.byte_valid = 1'b1;
      bus.byte_in = b[k];
      if (mid && k == 40) begin
        bus.start = 1'b1;
        bus.len   = 7'd1;
      end
      to = 1'b1;
      for (int t = 0; t < 500; t++) begin
        @(negedge clk);
        if (bus.byte_ready) begin
          to = 1'b0;
          break;
        end
      end
      if (to) begin
        chk("ready_timeout", 64'd1, 64'd0);
        bus.byte_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (k % 4 == 3) begin
        bus.byte_valid = 1'b0;
        @(negedge clk);
        chk("write_timing", 64'({bus.mem_we, bus.mem_waddr}),
            64'({1'b1, 6'(k / 4)}));
        @(posedge clk); #1;
      end
    end
    bus.byte_valid = 1'b0;
    to = 1'b1;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (bus.done) begin
        to = 1'b0;
        break;
      end
    end
    chk("done_seen", 64'(to), 64'd0);
    @(negedge clk);
    chk("after_done", 64'({bus.core_hold, bus.busy,
                           bus.done, bus.byte_ready}), 64'd0);
    if (gap == 0 && !to)
      chk("latency", 64'(lat), 64'(DEPTH + 5 * neff + 1));
    chk("ready_seen", 64'(ready_cnt != rc0), 64'(nb > 0));
    chk("writes_left", 64'(exp_q.size()), 64'd0);
    cmp_mem();
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.len = '0;
    bus.byte_in = '0;
    bus.byte_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("reset_idle", 64'(outs()), 64'd0);
    end

    stim = '{8'h93, 8'h00, 8'h50, 8'h00,
             8'h13, 8'h01, 8'h50, 8'h00};
    run_load(2, 0, 1'b0, -1);
    chk("word0", 64'(shadow[0]), 64'h0050_0093);
    chk("word1", 64'(shadow[1]), 64'h0050_0113);
    run_load(2, 3, 1'b0, -1);
    stim.delete();

    run_load(0, 0, 1'b0, -1);
    run_load(100, 0, 1'b1, -1);
    chk("last_addr", 64'(bus.mem_waddr), 64'd63);
    run_load(2, 0, 1'b0, 6);
    run_load(3, 0, 1'b0, -1);
    for (int r = 0; r < 3; r++)
      run_load($urandom_range(1, 20), $urandom_range(0, 2),
               1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
